// File: rtl/yuyin_play_sched.sv
// Voice-chip playback scheduler: queues parser voice requests and plays them in order.
// Optional macro VOICE_REPEAT_EN: each code-10 phrase is played twice back to back.
module yuyin_play_sched #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned START_CYCLES = 50000,
    parameter int unsigned BUSY_TIMEOUT = 5000000,
    parameter int unsigned GAP_CYCLES   = 2500000,
    parameter logic [6:0]  PROMPT_ADDR  = 7'h7E
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    yuyin_one_en,
    input  logic [6:0]                    yuyin_addr,
    input  logic                          voice_busy,
    output logic [6:0]                    voice_addr,
    output logic                          voice_start,
    output logic                          sched_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf_pulse,
    output logic                          tmo_pulse
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned LW     = AW + 1;
    localparam int unsigned MAX_SG = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
    localparam int unsigned MAXC   = (BUSY_TIMEOUT > MAX_SG) ? BUSY_TIMEOUT : MAX_SG;
    localparam int unsigned CW     = $clog2(MAXC + 1);
`ifdef VOICE_REPEAT_EN
    localparam int unsigned EW     = 8;
`else
    localparam int unsigned EW     = 7;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_PLAYING,
        S_GAP
    } state_t;

    logic [1:0]    r_en_d;
    logic          r_req_v;
    logic [EW-1:0] r_req_data;
    logic          r_vb_s1;
    logic          r_vb_s2;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_ovf_pulse;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [6:0]    r_voice_addr;
    logic          r_voice_start;
    logic          r_sched_busy;
    logic          r_tmo_pulse;
    logic          r_rep;

    logic          w_req;
    logic [EW-1:0] w_req_data;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic [EW-1:0] w_head;
    logic          w_head_rep;

    // Rising request: only a transition out of 00 counts, so held levels fire once.
    assign w_req = (r_en_d == 2'b00) && ((yuyin_one_en == 2'b01) || (yuyin_one_en == 2'b10));

`ifdef VOICE_REPEAT_EN
    assign w_req_data = (yuyin_one_en == 2'b10) ? {1'b1, yuyin_addr} : {1'b0, PROMPT_ADDR};
    assign w_head_rep = w_head[EW-1];
`else
    assign w_req_data = (yuyin_one_en == 2'b10) ? yuyin_addr : PROMPT_ADDR;
    assign w_head_rep = 1'b0;
`endif

    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_push  = r_req_v && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    // Request edge detect and busy synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_d     <= 2'b00;
            r_req_v    <= 1'b0;
            r_req_data <= '0;
            r_vb_s1    <= 1'b0;
            r_vb_s2    <= 1'b0;
        end else begin
            r_en_d     <= yuyin_one_en;
            r_req_v    <= w_req;
            r_req_data <= w_req_data;
            r_vb_s1    <= voice_busy;
            r_vb_s2    <= r_vb_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_req_data;
        end
    end

    // Queue pointers and occupancy; a pop in the same cycle makes room for a push on full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_ovf_pulse <= 1'b0;
        end else begin
            r_ovf_pulse <= r_req_v && w_full && !w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Playback sequencer; the counter is cleared on every state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_voice_addr  <= '0;
            r_voice_start <= 1'b0;
            r_sched_busy  <= 1'b0;
            r_tmo_pulse   <= 1'b0;
            r_rep         <= 1'b0;
        end else begin
            r_tmo_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_rep <= 1'b0;
                    if (w_pop) begin
                        r_state       <= S_START;
                        r_cnt         <= '0;
                        r_voice_addr  <= w_head[6:0];
                        r_voice_start <= 1'b1;
                        r_sched_busy  <= 1'b1;
                        r_rep         <= w_head_rep;
                    end
                end
                S_START: begin
                    if (r_cnt == CW'(START_CYCLES - 1)) begin
                        r_state       <= S_WAIT_BUSY;
                        r_cnt         <= '0;
                        r_voice_start <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_BUSY: begin
                    if (r_vb_s2) begin
                        r_state <= S_PLAYING;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        r_state     <= S_GAP;
                        r_cnt       <= '0;
                        r_tmo_pulse <= 1'b1;
                        r_rep       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_PLAYING: begin
                    if (!r_vb_s2) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                    end
                end
                S_GAP: begin
                    if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                        r_cnt <= '0;
                        if (r_rep) begin
                            r_state       <= S_START;
                            r_voice_start <= 1'b1;
                            r_rep         <= 1'b0;
                        end else begin
                            r_state      <= S_IDLE;
                            r_sched_busy <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_cnt         <= '0;
                    r_voice_start <= 1'b0;
                    r_sched_busy  <= 1'b0;
                    r_rep         <= 1'b0;
                end
            endcase
        end
    end

    assign voice_addr  = r_voice_addr;
    assign voice_start = r_voice_start;
    assign sched_busy  = r_sched_busy;
    assign fifo_level  = r_level;
    assign ovf_pulse   = r_ovf_pulse;
    assign tmo_pulse   = r_tmo_pulse;

endmodule

// File: tb/tb_yuyin_play_sched.sv
// Scoreboard bench for yuyin_play_sched: expected phrase addresses are queued per request
// and popped by a monitor on every voice_start rising edge.
module tb_yuyin_play_sched;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SC    = 4;
    localparam int unsigned BT    = 20;
    localparam int unsigned GC    = 6;
`ifdef VOICE_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] yuyin_one_en = 2'b00;
    logic [6:0] yuyin_addr = 7'h00;
    logic       voice_busy = 1'b0;
    logic [6:0] voice_addr;
    logic       voice_start;
    logic       sched_busy;
    logic [2:0] fifo_level;
    logic       ovf_pulse;
    logic       tmo_pulse;

    yuyin_play_sched #(
        .FIFO_DEPTH   (DEPTH),
        .START_CYCLES (SC),
        .BUSY_TIMEOUT (BT),
        .GAP_CYCLES   (GC),
        .PROMPT_ADDR  (7'h7E)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .yuyin_one_en (yuyin_one_en),
        .yuyin_addr   (yuyin_addr),
        .voice_busy   (voice_busy),
        .voice_addr   (voice_addr),
        .voice_start  (voice_start),
        .sched_busy   (sched_busy),
        .fifo_level   (fifo_level),
        .ovf_pulse    (ovf_pulse),
        .tmo_pulse    (tmo_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_err = 0;
    logic [6:0] exp_q[$];
    logic [6:0] sb_exp;
    int         n_starts = 0;
    int         start_cyc = 0;
    int         width = 0;
    int         n_tmo = 0;
    int         tmo_cyc = 0;
    int         n_ovf = 0;
    int         lvl_peak = 0;
    int         sb_fall_cyc = 0;
    int         busy_fall_cyc = 0;
    int         req_cyc = 0;
    logic       prev_start = 1'b0;
    logic       prev_sb = 1'b0;
    bit         chip_en = 1'b1;
    int         play_len = 10;
    event       ev_start;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Expected play list; code-10 phrases repeat when the replay feature is built in.
    task automatic exp_play(input logic [6:0] a, input logic [1:0] code);
        exp_q.push_back(a);
        if (REP != 0 && code == 2'b10) exp_q.push_back(a);
    endtask

    task automatic req(input logic [1:0] code, input logic [6:0] a, input int hold);
        @(posedge clk);
        #1;
        yuyin_one_en = code;
        yuyin_addr   = a;
        req_cyc      = cyc;
        repeat (hold) @(posedge clk);
        #1;
        yuyin_one_en = 2'b00;
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int n = 0;
        while (n_starts < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(n_starts >= target), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        repeat (4) @(negedge clk);
        while ((sched_busy || fifo_level != 3'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(sched_busy), 0);
    endtask

    // Monitor: scoreboard pop on start edges, pulse width, event counters.
    initial begin
        forever begin
            @(negedge clk);
            if (voice_start && !prev_start) begin
                n_starts++;
                start_cyc = cyc;
                width     = 1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_start_addr", int'(voice_addr), -1);
                end else begin
                    sb_exp = exp_q.pop_front();
                    chk("start_addr", int'(voice_addr), int'(sb_exp));
                end
                -> ev_start;
            end else if (voice_start) begin
                width++;
            end else if (prev_start) begin
                chk("start_width", width, SC);
            end
            if (tmo_pulse) begin
                n_tmo++;
                tmo_cyc = cyc;
            end
            if (ovf_pulse) n_ovf++;
            if (int'(fifo_level) > lvl_peak) lvl_peak = int'(fifo_level);
            if (prev_sb && !sched_busy) sb_fall_cyc = cyc;
            prev_start = voice_start;
            prev_sb    = sched_busy;
        end
    end

    // Voice chip model: busy rises 3 cycles after a start and stays high play_len cycles.
    initial begin
        forever begin
            @(ev_start);
            if (chip_en) begin
                repeat (3) @(posedge clk);
                #1 voice_busy = 1'b1;
                repeat (play_len) @(posedge clk);
                #1 voice_busy = 1'b0;
                busy_fall_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_err);
        $fatal(1);
    end

    initial begin
        int base;
        int s1;
        int ovf0;
        int tmo0;
        int n;

        repeat (3) @(negedge clk);
        chk("rst_voice_addr", int'(voice_addr), 0);
        chk("rst_voice_start", int'(voice_start), 0);
        chk("rst_sched_busy", int'(sched_busy), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);
        chk("rst_ovf_pulse", int'(ovf_pulse), 0);
        chk("rst_tmo_pulse", int'(tmo_pulse), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single code-10 phrase: latency 3, start width 4, gap 6 plus 3 sync/register cycles.
        chip_en  = 1'b1;
        play_len = 10;
        base     = n_starts;
        exp_play(7'h12, 2'b10);
        req(2'b10, 7'b0010010, 1);
        wait_starts(base + 1, 100, "t1_start_seen");
        chk("t1_latency", start_cyc - req_cyc, 3);
        wait_idle(500, "t1_idle");
        chk("t1_sched_fall", sb_fall_cyc - busy_fall_cyc, GC + 3);
        chk("t1_nstarts", n_starts - base, 1 + REP);

        // Header ack held for 50 cycles: one play of the prompt.
        base     = n_starts;
        lvl_peak = 0;
        exp_play(7'h7E, 2'b01);
        req(2'b01, 7'h00, 50);
        wait_idle(500, "t2_idle");
        chk("t2_level_peak", lvl_peak, 1);
        chk("t2_nstarts", n_starts - base, 1);

        // Six back-to-back requests: one plays, four queue, the sixth overflows.
        base     = n_starts;
        lvl_peak = 0;
        ovf0     = n_ovf;
        exp_play(7'h12, 2'b10);
        exp_play(7'h14, 2'b10);
        exp_play(7'h16, 2'b10);
        exp_play(7'h18, 2'b10);
        exp_play(7'h32, 2'b10);
        req(2'b10, 7'h12, 1);
        req(2'b10, 7'h14, 1);
        req(2'b10, 7'h16, 1);
        req(2'b10, 7'h18, 1);
        req(2'b10, 7'h32, 1);
        req(2'b10, 7'h34, 1);
        repeat (3) @(negedge clk);
        chk("t3_level_full", int'(fifo_level), 4);
        chk("t3_ovf_count", n_ovf - ovf0, 1);
        wait_idle(3000, "t3_idle");
        chk("t3_level_peak", lvl_peak, 4);
        chk("t3_nstarts", n_starts - base, 5 * (1 + REP));

        // Busy never rises: timeout 20 cycles into WAIT_BUSY, then the next phrase plays.
        chip_en = 1'b0;
        base    = n_starts;
        tmo0    = n_tmo;
        exp_q.push_back(7'h40);
        exp_play(7'h41, 2'b10);
        req(2'b10, 7'h40, 1);
        req(2'b10, 7'h41, 1);
        wait_starts(base + 1, 100, "t4_first_start");
        s1 = start_cyc;
        n  = 0;
        while (n_tmo == tmo0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chip_en = 1'b1;
        chk("t4_tmo_seen", n_tmo - tmo0, 1);
        chk("t4_tmo_time", tmo_cyc - s1, SC + BT);
        wait_starts(base + 2, 100, "t4_second_start");
        chk("t4_restart", start_cyc - tmo_cyc, GC + 1);
        wait_idle(1000, "t4_idle");
        chk("t4_tmo_total", n_tmo - tmo0, 1);
        chk("t4_nstarts", n_starts - base, 2 + REP);

        // Reset while playing with two phrases queued: everything is discarded.
        play_len = 40;
        base     = n_starts;
        exp_q.push_back(7'h50);
        req(2'b10, 7'h50, 1);
        req(2'b10, 7'h51, 1);
        req(2'b10, 7'h52, 1);
        wait_starts(base + 1, 100, "t5_start");
        repeat (12) @(negedge clk);
        chk("t5_level_before", int'(fifo_level), 2);
        chk("t5_busy_before", int'(sched_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_voice_start", int'(voice_start), 0);
        chk("t5_rst_fifo_level", int'(fifo_level), 0);
        chk("t5_rst_sched_busy", int'(sched_busy), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("t5_nstarts", n_starts - base, 1);
        chk("t5_sched_busy_after", int'(sched_busy), 0);

        // Code 11 never requests, neither does 11 -> 10 without passing through 00.
        base = n_starts;
        req(2'b11, 7'h33, 10);
        @(posedge clk);
        #1 yuyin_one_en = 2'b11;
        @(posedge clk);
        #1 yuyin_one_en = 2'b10;
        @(posedge clk);
        #1 yuyin_one_en = 2'b00;
        repeat (30) @(negedge clk);
        chk("t6_nstarts", n_starts - base, 0);
        chk("t6_level", int'(fifo_level), 0);

`ifdef VOICE_REPEAT_EN
        play_len = 10;
        base     = n_starts;
        exp_play(7'h5A, 2'b10);
        req(2'b10, 7'h5A, 1);
        wait_idle(1000, "t7_idle");
        chk("t7_replay_nstarts", n_starts - base, 2);
        base = n_starts;
        exp_play(7'h7E, 2'b01);
        req(2'b01, 7'h00, 1);
        wait_idle(1000, "t7_prompt_idle");
        chk("t7_prompt_nstarts", n_starts - base, 1);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
